// File: rtl/lcd_timing_gen_pkg.sv
// Shared LCD panel timing constants and width helper. The pixel-source blocks use
// the same package.
package lcd_timing_gen_pkg;

    // Default 800x480 panel timing. All values are pixel ticks or lines.
    localparam int LCD_COL_MAX = 800;
    localparam int LCD_FIL_MAX = 480;
    localparam int LCD_H_FP    = 210;
    localparam int LCD_H_SYNC  = 30;
    localparam int LCD_H_BP    = 16;
    localparam int LCD_V_FP    = 22;
    localparam int LCD_V_SYNC  = 13;
    localparam int LCD_V_BP    = 10;
    localparam int LCD_H_TOTAL = LCD_COL_MAX + LCD_H_FP + LCD_H_SYNC + LCD_H_BP;  // 1056
    localparam int LCD_V_TOTAL = LCD_FIL_MAX + LCD_V_FP + LCD_V_SYNC + LCD_V_BP;  // 525

    // Number of bits needed to hold 'value' (at least 1). clogb2(799) = 10.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_contador_mod.sv
// Modulo-N counter. It resets to N-1, so the first enabled step lands on 0.
// nxt_o is the value the counter takes on the coming edge, so registered decodes
// downstream can stay in step with it. carry_o marks an enabled step that wraps.
module lcd_contador_mod #(
    parameter int N = 1056,
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] nxt_o,
    output logic         carry_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear to N-1 has priority, then increment with wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LAST;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register. Asynchronous reset goes to the last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nxt_o   = cnt_d;
    assign carry_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator. It makes a CLK/2 pixel clock and runs horizontal and
// vertical counters. From the counters it decodes registered HD, VD, DEN, the
// pixel coordinates and a frame-wrap pulse. The outputs are decoded from the next
// counter values, so they change on the same edge as the counters.
module lcd_timing_gen
    import lcd_timing_gen_pkg::*;
#(
    parameter int col_max_pantalla  = LCD_COL_MAX,
    parameter int fila_max_pantalla = LCD_FIL_MAX,
    parameter int H_FP              = LCD_H_FP,
    parameter int H_SYNC            = LCD_H_SYNC,
    parameter int H_BP              = LCD_H_BP,
    parameter int V_FP              = LCD_V_FP,
    parameter int V_SYNC            = LCD_V_SYNC,
    parameter int V_BP              = LCD_V_BP,
    parameter int n_col             = clogb2(col_max_pantalla - 1),
    parameter int n_fil             = clogb2(fila_max_pantalla - 1)
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             EN,
    output logic             NCLK,
    output logic             HD,
    output logic             VD,
    output logic             DEN,
    output logic [n_col-1:0] columna,
    output logic [n_fil-1:0] fila,
    output logic             fin_trama
);

    localparam int H_TOT = col_max_pantalla + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = fila_max_pantalla + V_FP + V_SYNC + V_BP;
    localparam int HW    = clogb2(H_TOT - 1);
    localparam int VW    = clogb2(V_TOT - 1);

    // Region boundaries at the full counter width. Sync spans [LO, HI).
    localparam logic [HW-1:0] H_VIS     = HW'(col_max_pantalla);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(col_max_pantalla + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(col_max_pantalla + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_VIS     = VW'(fila_max_pantalla);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(fila_max_pantalla + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(fila_max_pantalla + V_FP + V_SYNC);

    logic             fase_q;
    logic             fase_d;
    logic             tick;
    logic [HW-1:0]    hnxt;
    logic [VW-1:0]    vnxt;
    logic             hcarry;
    logic             vcarry;

    logic             hd_q,  hd_d;
    logic             vd_q,  vd_d;
    logic             den_q, den_d;
    logic             fin_q, fin_d;
    logic [n_col-1:0] columna_q, columna_d;
    logic [n_fil-1:0] fila_q,    fila_d;

    // Phase toggles every edge while running. A tick is any edge with fase high.
    always_comb begin
        fase_d = EN ? !fase_q : 1'b0;
    end

    // Phase register. It is also the pixel clock, high in the cycle before a tick.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            fase_q <= 1'b0;
        end else begin
            fase_q <= fase_d;
        end
    end

    assign tick = EN && fase_q;

    // Pixel counter. It steps on every tick.
    lcd_contador_mod #(
        .N (H_TOT),
        .W (HW)
    ) u_hcnt (
        .clk_i   (CLK),
        .rst_ni  (RST_n),
        .en_i    (tick),
        .clr_i   (!EN),
        .nxt_o   (hnxt),
        .carry_o (hcarry)
    );

    // Line counter. It steps only when the pixel counter wraps.
    lcd_contador_mod #(
        .N (V_TOT),
        .W (VW)
    ) u_vcnt (
        .clk_i   (CLK),
        .rst_ni  (RST_n),
        .en_i    (hcarry),
        .clr_i   (!EN),
        .nxt_o   (vnxt),
        .carry_o (vcarry)
    );

    // Decode the outputs from the next counter values. Idle values apply while disabled.
    always_comb begin
        hd_d      = 1'b1;
        vd_d      = 1'b1;
        den_d     = 1'b0;
        columna_d = '0;
        fila_d    = '0;
        fin_d     = 1'b0;
        if (EN) begin
            hd_d  = !((hnxt >= H_SYNC_LO) && (hnxt < H_SYNC_HI));
            vd_d  = !((vnxt >= V_SYNC_LO) && (vnxt < V_SYNC_HI));
            den_d = (hnxt < H_VIS) && (vnxt < V_VIS);
            if (den_d) begin
                columna_d = hnxt[n_col-1:0];
                fila_d    = vnxt[n_fil-1:0];
            end
            // The line counter wraps only on the tick that also wraps the pixel counter.
            fin_d = vcarry;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            hd_q      <= 1'b1;
            vd_q      <= 1'b1;
            den_q     <= 1'b0;
            columna_q <= '0;
            fila_q    <= '0;
            fin_q     <= 1'b0;
        end else begin
            hd_q      <= hd_d;
            vd_q      <= vd_d;
            den_q     <= den_d;
            columna_q <= columna_d;
            fila_q    <= fila_d;
            fin_q     <= fin_d;
        end
    end

    assign NCLK      = fase_q;
    assign HD        = hd_q;
    assign VD        = vd_q;
    assign DEN       = den_q;
    assign columna   = columna_q;
    assign fila      = fila_q;
    assign fin_trama = fin_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a reduced panel (16x8, H total 23, V total 13).
// The reference model counts enabled CLK edges and derives the pixel position
// with division and modulo.
module tb_lcd_timing_gen;

    localparam int COLS = 16;
    localparam int ROWS = 8;
    localparam int HFP  = 3;
    localparam int HSY  = 2;
    localparam int HBP  = 2;
    localparam int VFP  = 2;
    localparam int VSY  = 2;
    localparam int VBP  = 1;
    localparam int HT   = COLS + HFP + HSY + HBP;
    localparam int VT   = ROWS + VFP + VSY + VBP;
    localparam int NC   = 4;
    localparam int NF   = 3;
    localparam int W    = 5 + NC + NF;
    localparam int LIM  = 4 * HT * VT;
    localparam logic [W-1:0] RST_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {NC{1'b0}}, {NF{1'b0}}};

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          nclk, hd, vd, den, fin;
    logic [NC-1:0] columna;
    logic [NF-1:0] fila;
    logic [W-1:0]  act;

    logic [W-1:0]  exp_q[$];
    int            n_vec;
    int            n_fail;
    int            cyc;
    int            k;

    lcd_timing_gen #(
        .col_max_pantalla  (COLS),
        .fila_max_pantalla (ROWS),
        .H_FP              (HFP),
        .H_SYNC            (HSY),
        .H_BP              (HBP),
        .V_FP              (VFP),
        .V_SYNC            (VSY),
        .V_BP              (VBP),
        .n_col             (NC),
        .n_fil             (NF)
    ) dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .EN        (en),
        .NCLK      (nclk),
        .HD        (hd),
        .VD        (vd),
        .DEN       (den),
        .columna   (columna),
        .fila      (fila),
        .fin_trama (fin)
    );

    assign act = {nclk, hd, vd, den, fin, columna, fila};

    // Clock and cycle count.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs after k enabled edges since the block left its idle state.
    function automatic logic [W-1:0] expect_vec(input int kk);
        int ticks, p, h, v;
        logic e_nclk, e_hd, e_vd, e_den, e_fin;
        logic [NC-1:0] e_col;
        logic [NF-1:0] e_fil;
        ticks = kk / 2;
        if (ticks == 0) begin
            p = -1;
            h = HT - 1;
            v = VT - 1;
        end else begin
            p = ticks - 1;
            h = p % HT;
            v = (p / HT) % VT;
        end
        e_nclk = (kk % 2) == 1;
        e_fin  = (ticks > 0) && ((kk % 2) == 0) && ((p % (HT * VT)) == 0);
        e_den  = (h < COLS) && (v < ROWS);
        e_hd   = !((h >= COLS + HFP) && (h < COLS + HFP + HSY));
        e_vd   = !((v >= ROWS + VFP) && (v < ROWS + VFP + VSY));
        e_col  = e_den ? NC'(h) : '0;
        e_fil  = e_den ? NF'(v) : '0;
        return {e_nclk, e_hd, e_vd, e_den, e_fin, e_col, e_fil};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b required %b (nclk,hd,vd,den,fin,col,fila)",
                     name, cyc, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d required %0d", name, cyc, got, want);
        end
    endtask

    // Reference model: one expected output vector for each clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            exp_q.delete();
            exp_q.push_back(expect_vec(0));
        end else begin
            if (!en) k = 0;
            else     k = k + 1;
            exp_q.push_back(expect_vec(k));
        end
    end

    // Monitor: pop the expected vector and compare on the opposite edge.
    always @(negedge clk) begin
        if (exp_q.size() == 0) begin
            check("underflow", act, ~act);
        end else begin
            check("scoreboard", act, exp_q.pop_front());
        end
    end

    // Advance one cycle. Inputs change 2 time units after the active edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int t;
        int c0;
        n_vec  = 0;
        n_fail = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        repeat (3) step();
        check("reset_state", act, RST_VEC);
        rst_n = 1'b1;

        // Run freely for two frames and a bit more.
        repeat (2 * 2 * HT * VT + 40) step();

        // HD low width in CLK cycles.
        t = 0;
        while (hd !== 1'b1 && t < LIM) begin step(); t++; end
        t = 0;
        while (hd !== 1'b0 && t < LIM) begin step(); t++; end
        check_int("hd_wait", int'(t < LIM), 1);
        t = 0;
        while (hd === 1'b0 && t < LIM) begin step(); t++; end
        check_int("hd_width", t, 2 * HSY);

        // Spacing between frame pulses.
        t = 0;
        while (fin !== 1'b1 && t < LIM) begin step(); t++; end
        c0 = cyc;
        step();
        t = 0;
        while (fin !== 1'b1 && t < LIM) begin step(); t++; end
        check_int("frame_period", cyc - c0, 2 * HT * VT);

        // Drop EN in the middle of the visible area, then bring it back.
        t = 0;
        while (!(den === 1'b1 && columna == NC'(8) && fila == NF'(3)) && t < LIM) begin
            step(); t++;
        end
        check_int("mid_wait", int'(t < LIM), 1);
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        repeat (HT * VT) step();

        // Assert reset asynchronously while HD is low.
        t = 0;
        while (hd !== 1'b0 && t < LIM) begin step(); t++; end
        check_int("hd_low_wait", int'(t < LIM), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", act, RST_VEC);
        step();
        rst_n = 1'b1;

        // Random EN drops, mostly running.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 199) != 0);
            step();
        end
        en = 1'b1;
        repeat (HT * VT + 10) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
